// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio
//   Memory-mapped 8N1 UART transmitter sitting on the single-cycle core's
//   data-memory port. Stores to TXDATA queue a byte in a small FIFO, and the TX
//   FSM shifts the queued bytes out on txd. STATUS is returned combinationally
//   so that a load completes in the same cycle.
//
//   Register window (8 bytes at MMIO_BASE, alu_result[1:0] ignored):
//     +0 TXDATA  W: push write_data[7:0]        R: 0
//     +4 STATUS  W: write_data[10]=1 clears overflow
//                R: {20'b0, tx_busy, overflow, full, empty, count[7:0]}
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   mem_write   core store strobe
//   alu_result  core data address
//   write_data  core store data
//   mmio_sel    address falls inside the window
//   mmio_rdata  read data for the addressed register
//   txd         UART serial output, idle high, registered
//   tx_busy     a frame is being shifted
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | line high, waiting for a byte in the FIFO
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | 8 data bits, LSB first, CLKS_PER_BIT each
// STOP  | stop bit (high); chains into START if FIFO non-empty

module uart_tx_mmio #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] MMIO_BASE    = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_write,
    input  logic [31:0] alu_result,
    input  logic [31:0] write_data,
    output logic        mmio_sel,
    output logic [31:0] mmio_rdata,
    output logic        txd,
    output logic        tx_busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t         state, state_nxt;
    logic [BW-1:0]  baud_cnt, baud_nxt;
    logic [2:0]     bit_idx, bit_nxt;
    logic [7:0]     shift_reg, shift_nxt;
    logic           txd_reg, txd_nxt;

    logic [7:0]     fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           overflow;

    logic           hit, wr_txdata, wr_status;
    logic           push, pop, ovf_set, ovf_clr;
    logic           empty, full, baud_tc;
    logic [7:0]     count_ext;
    logic           unused_bits;

    // ------------------------------------------------------------ decode
    assign hit       = (alu_result[31:3] == MMIO_BASE[31:3]);
    assign mmio_sel  = hit;
    assign wr_txdata = mem_write && hit && !alu_result[2];
    assign wr_status = mem_write && hit &&  alu_result[2];

    assign empty     = (count == '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign count_ext = 8'(count);

    // A pop in the same cycle does not free a slot: full is the pre-edge value.
    assign push      = wr_txdata && !full;
    assign ovf_set   = wr_txdata &&  full;
    assign ovf_clr   = wr_status && write_data[10];

    assign unused_bits = ^{write_data[31:11], write_data[9:8], alu_result[1:0]};

    always_comb begin
        mmio_rdata = '0;
        if (hit && alu_result[2]) begin
            mmio_rdata = {20'b0, tx_busy, overflow, full, empty, count_ext};
        end
    end

    // ------------------------------------------------------------ FIFO
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= write_data[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Set has priority over a same-cycle clear.
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------ TX FSM
    assign baud_tc = (baud_cnt == BW'(CLKS_PER_BIT - 1));
    assign txd     = txd_reg;
    assign tx_busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            txd_reg   <= 1'b1;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_idx   <= bit_nxt;
            shift_reg <= shift_nxt;
            txd_reg   <= txd_nxt;
        end
    end

    // txd_nxt is the line level for the coming cycle, so the registered txd
    // changes on the same edge as the state.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift_reg;
        txd_nxt   = txd_reg;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                txd_nxt  = 1'b1;
                baud_nxt = '0;
                if (!empty) begin
                    pop       = 1'b1;
                    shift_nxt = fifo_mem[rd_ptr];
                    bit_nxt   = '0;
                    txd_nxt   = 1'b0;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                txd_nxt = 1'b0;
                if (baud_tc) begin
                    baud_nxt  = '0;
                    txd_nxt   = shift_reg[0];
                    state_nxt = ST_DATA;
                end else begin
                    baud_nxt = baud_cnt + BW'(1);
                end
            end
            ST_DATA: begin
                if (baud_tc) begin
                    baud_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        txd_nxt   = 1'b1;
                        state_nxt = ST_STOP;
                    end else begin
                        shift_nxt = {1'b0, shift_reg[7:1]};
                        bit_nxt   = bit_idx + 3'd1;
                        txd_nxt   = shift_reg[1];
                    end
                end else begin
                    baud_nxt = baud_cnt + BW'(1);
                end
            end
            ST_STOP: begin
                txd_nxt = 1'b1;
                if (baud_tc) begin
                    baud_nxt = '0;
                    if (!empty) begin
                        pop       = 1'b1;
                        shift_nxt = fifo_mem[rd_ptr];
                        bit_nxt   = '0;
                        txd_nxt   = 1'b0;
                        state_nxt = ST_START;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    baud_nxt = baud_cnt + BW'(1);
                end
            end
            default: begin
                txd_nxt   = 1'b1;
                baud_nxt  = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
